// File: rtl/automat_pkg.sv
// Shared encodings for the coffee vending controller.
// State codes and accepted coin values.
package automat_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_VEND   = 2'd1,
      ST_CHANGE = 2'd2
   } state_t;

   localparam int VAL_1LEU = 1;
   localparam int VAL_5LEI = 5;

endpackage

// File: rtl/automat_cafea_param.sv
// Parametrised coffee vending FSM: coin credit, timed dispense,
// serial one-leu change pulses, refund and coin rejection.
module automat_cafea_param
   import automat_pkg::*;
#(
   parameter int PRICE       = 3,
   parameter int CREDIT_W    = 4,
   parameter int VEND_CYCLES = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                B1leu,
   input  logic                B5lei,
   input  logic                cancel,
   output logic                cafea,
   output logic                rest,
   output logic                coin_reject,
   output logic                busy,
   output logic [CREDIT_W-1:0] credit
);

   localparam int SUM_W      = CREDIT_W + 3;
   localparam int MAX_CREDIT = 2**CREDIT_W - 1;
   localparam int CNT_W      = (VEND_CYCLES > 1) ? $clog2(VEND_CYCLES) : 1;

   state_t              state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                rej_q, rej_d;
   logic [SUM_W-1:0]    sum, acc;
   logic                coin;

   assign coin = B1leu | B5lei;

   always_comb begin
      sum = SUM_W'(credit_q);
      if (B1leu) sum = sum + SUM_W'(VAL_1LEU);
      if (B5lei) sum = sum + SUM_W'(VAL_5LEI);
   end

   always_comb begin
      state_d  = state_q;
      credit_d = credit_q;
      cnt_d    = cnt_q;
      rej_d    = 1'b0;
      acc      = sum;
      unique case (state_q)
         ST_IDLE: begin
            // An overflowing cycle drops every coin but still honours cancel.
            if (sum > SUM_W'(MAX_CREDIT)) begin
               rej_d = 1'b1;
               acc   = SUM_W'(credit_q);
            end
            if (cancel) begin
               if (acc != '0) begin
                  credit_d = CREDIT_W'(acc);
                  state_d  = ST_CHANGE;
               end
            end else if (acc >= SUM_W'(PRICE)) begin
               credit_d = CREDIT_W'(acc - SUM_W'(PRICE));
               cnt_d    = CNT_W'(VEND_CYCLES - 1);
               state_d  = ST_VEND;
            end else begin
               credit_d = CREDIT_W'(acc);
            end
         end
         ST_VEND: begin
            rej_d = coin;
            if (cnt_q == '0) begin
               state_d = (credit_q != '0) ? ST_CHANGE : ST_IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_CHANGE: begin
            rej_d = coin;
            if (credit_q <= CREDIT_W'(1)) begin
               credit_d = '0;
               state_d  = ST_IDLE;
            end else begin
               credit_d = credit_q - 1'b1;
            end
         end
         default: begin
            state_d  = ST_IDLE;
            credit_d = '0;
            cnt_d    = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         credit_q <= '0;
         cnt_q    <= '0;
         rej_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         credit_q <= credit_d;
         cnt_q    <= cnt_d;
         rej_q    <= rej_d;
      end
   end

   assign cafea       = (state_q == ST_VEND);
   assign rest        = (state_q == ST_CHANGE);
   assign busy        = (state_q != ST_IDLE);
   assign coin_reject = rej_q;
   assign credit      = credit_q;

endmodule
